// File: rtl/seg_word_decoder_if.sv
// Seven-segment receive bus: pin-side inputs and decoded glyph/word-match outputs.
// SEG_WORD_COUNT_EN adds the word_count signal.
interface seg_word_decoder_if;
   logic [6:0] segments;
   logic       decimal;
   logic [2:0] glyph_code;
   logic       glyph_strobe;
   logic       hello_det;
   logic       rpog_det;
   logic       bad_glyph;
`ifdef SEG_WORD_COUNT_EN
   logic [7:0] word_count;

   modport master (output segments, decimal,
                   input  glyph_code, glyph_strobe, hello_det, rpog_det, bad_glyph, word_count);
   modport slave  (input  segments, decimal,
                   output glyph_code, glyph_strobe, hello_det, rpog_det, bad_glyph, word_count);
`else
   modport master (output segments, decimal,
                   input  glyph_code, glyph_strobe, hello_det, rpog_det, bad_glyph);
   modport slave  (input  segments, decimal,
                   output glyph_code, glyph_strobe, hello_det, rpog_det, bad_glyph);
`endif
endinterface

// File: rtl/seg_word_decoder.sv
// Seven-segment glyph receiver: synchronizer, stability filter, letter decoder and HELLO/RPOG matcher.
// Optional SEG_WORD_COUNT_EN adds a saturating count of detected words.
module seg_word_decoder #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input logic               clk,
   input logic               rst_n,
   seg_word_decoder_if.slave bus
);
   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

   localparam logic [2:0] CODE_H     = 3'd0;
   localparam logic [2:0] CODE_E     = 3'd1;
   localparam logic [2:0] CODE_L     = 3'd2;
   localparam logic [2:0] CODE_O     = 3'd3;
   localparam logic [2:0] CODE_R     = 3'd4;
   localparam logic [2:0] CODE_P     = 3'd5;
   localparam logic [2:0] CODE_G     = 3'd6;
   localparam logic [2:0] CODE_BLANK = 3'd7;

   typedef enum logic [2:0] {ST_IDLE, ST_H, ST_HE, ST_HEL, ST_R, ST_RP, ST_RPO} state_t;

   // Returns {bad, code}; unknown patterns report as bad blank
   function automatic logic [3:0] decode_glyph(input logic [6:0] pat);
      case (pat)
         7'b1110100: decode_glyph = {1'b0, CODE_H};
         7'b1111001: decode_glyph = {1'b0, CODE_E};
         7'b0111000: decode_glyph = {1'b0, CODE_L};
         7'b0111111: decode_glyph = {1'b0, CODE_O};
         7'b1010000: decode_glyph = {1'b0, CODE_R};
         7'b1110011: decode_glyph = {1'b0, CODE_P};
         7'b1111101: decode_glyph = {1'b0, CODE_G};
         7'b0000000: decode_glyph = {1'b0, CODE_BLANK};
         default:    decode_glyph = {1'b1, CODE_BLANK};
      endcase
   endfunction

   logic [7:0]       sync1, sync2;
   logic [6:0]       sample_c;
   logic [6:0]       candidate, last_accepted;
   logic [CNT_W-1:0] count;
   logic             accept_c;
   logic [3:0]       dec_c;
   logic             bad_c;
   logic [2:0]       code_c, restart_c;
   state_t           state, state_next;
   logic             hello_c, rpog_c;

   logic [2:0] glyph_code_q;
   logic       glyph_strobe_q, hello_det_q, rpog_det_q, bad_glyph_q;

   assign sample_c  = sync2[7] ? sync2[6:0] : 7'b0000000;
   // Accept on the edge where the count reaches STABLE_CYCLES for a new glyph
   assign accept_c  = (sample_c == candidate) && (count == STABLE_LAST) && (candidate != last_accepted);
   assign dec_c     = decode_glyph(candidate);
   assign bad_c     = dec_c[3];
   assign code_c    = dec_c[2:0];
   assign restart_c = (code_c == CODE_H) ? 3'(ST_H) : (code_c == CODE_R) ? 3'(ST_R) : 3'(ST_IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1         <= '0;
         sync2         <= '0;
         candidate     <= '0;
         last_accepted <= '0;
         count         <= '0;
      end else begin
         sync1 <= {bus.decimal, bus.segments};
         sync2 <= sync1;
         if (sample_c != candidate) begin
            candidate <= sample_c;
            count     <= '0;
         end else if (count <= STABLE_LAST) begin
            count <= count + CNT_W'(1);
         end
         if (accept_c) last_accepted <= candidate;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   // Matcher advances only on accepted glyphs; blanks are transparent
   always_comb begin
      state_next = state;
      hello_c    = 1'b0;
      rpog_c     = 1'b0;
      if (accept_c) begin
         if (bad_c) begin
            state_next = ST_IDLE;
         end else if (code_c != CODE_BLANK) begin
            state_next = state_t'(restart_c);
            case (state)
               ST_H:   if (code_c == CODE_E) state_next = ST_HE;
               ST_HE:  if (code_c == CODE_L) state_next = ST_HEL;
               ST_HEL: begin
                  if (code_c == CODE_L) state_next = ST_HEL;
                  else if (code_c == CODE_O) begin
                     state_next = ST_IDLE;
                     hello_c    = 1'b1;
                  end
               end
               ST_R:   if (code_c == CODE_P) state_next = ST_RP;
               ST_RP:  if (code_c == CODE_O) state_next = ST_RPO;
               ST_RPO: begin
                  if (code_c == CODE_G) begin
                     state_next = ST_IDLE;
                     rpog_c     = 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         glyph_code_q   <= CODE_BLANK;
         glyph_strobe_q <= 1'b0;
         hello_det_q    <= 1'b0;
         rpog_det_q     <= 1'b0;
         bad_glyph_q    <= 1'b0;
      end else begin
         glyph_strobe_q <= accept_c;
         hello_det_q    <= hello_c;
         rpog_det_q     <= rpog_c;
         bad_glyph_q    <= accept_c & bad_c;
         if (accept_c) glyph_code_q <= code_c;
      end
   end

   assign bus.glyph_code   = glyph_code_q;
   assign bus.glyph_strobe = glyph_strobe_q;
   assign bus.hello_det    = hello_det_q;
   assign bus.rpog_det     = rpog_det_q;
   assign bus.bad_glyph    = bad_glyph_q;

`ifdef SEG_WORD_COUNT_EN
   logic [7:0] word_count_q;

   always_ff @(posedge clk) begin
      if (!rst_n)                                            word_count_q <= '0;
      else if ((hello_det_q | rpog_det_q) && word_count_q != 8'hFF) word_count_q <= word_count_q + 8'd1;
   end

   assign bus.word_count = word_count_q;
`endif
endmodule

// File: tb/tb_seg_word_decoder.sv
// Directed self-checking bench for seg_word_decoder: latency, word matching, glitches, bad glyphs, reset.
module tb_seg_word_decoder;
   localparam logic [6:0] SEG_H   = 7'b1110100;
   localparam logic [6:0] SEG_E   = 7'b1111001;
   localparam logic [6:0] SEG_L   = 7'b0111000;
   localparam logic [6:0] SEG_O   = 7'b0111111;
   localparam logic [6:0] SEG_R   = 7'b1010000;
   localparam logic [6:0] SEG_P   = 7'b1110011;
   localparam logic [6:0] SEG_G   = 7'b1111101;
   localparam logic [6:0] SEG_BLK = 7'b0000000;
   localparam logic [6:0] SEG_ALL = 7'b1111111;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_pass   = 0;

   int          strobes, hellos, rpogs, bads, hello_on_strobe, rpog_on_strobe, bad_on_strobe;
   logic [31:0] codes;
   int          first_edge;

   seg_word_decoder_if bus();

   seg_word_decoder #(.STABLE_CYCLES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic clear_mon();
      strobes = 0; hellos = 0; rpogs = 0; bads = 0;
      hello_on_strobe = 0; rpog_on_strobe = 0; bad_on_strobe = 0;
      codes = '0;
   endtask

   // Drive one pattern for n cycles, logging every output pulse seen
   task automatic hold(input logic [6:0] seg, input logic dec, input int n);
      bus.segments = seg;
      bus.decimal  = dec;
      repeat (n) begin
         @(posedge clk); #1;
         if (bus.glyph_strobe) begin
            strobes++;
            codes = {codes[27:0], 1'b0, bus.glyph_code};
         end
         if (bus.hello_det) hellos++;
         if (bus.rpog_det)  rpogs++;
         if (bus.bad_glyph) bads++;
         if (bus.hello_det && bus.glyph_strobe && bus.glyph_code == 3'd3) hello_on_strobe++;
         if (bus.rpog_det  && bus.glyph_strobe && bus.glyph_code == 3'd6) rpog_on_strobe++;
         if (bus.bad_glyph && bus.glyph_strobe && bus.glyph_code == 3'd7) bad_on_strobe++;
      end
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("rst_no_strobe", 32'(bus.glyph_strobe), 32'd0);
      check("rst_code", 32'(bus.glyph_code), 32'd7);
      check("rst_no_hello", 32'(bus.hello_det), 32'd0);
      rst_n = 1'b1;
   endtask

   task automatic check_count(input string tag, input int exp);
`ifdef SEG_WORD_COUNT_EN
      check(tag, 32'(bus.word_count), 32'(exp));
`endif
   endtask

   initial begin
      rst_n = 1'b0;
      bus.segments = SEG_BLK;
      bus.decimal  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_code", 32'(bus.glyph_code), 32'd7);
      check("reset_pulses", {28'd0, bus.glyph_strobe, bus.hello_det, bus.rpog_det, bus.bad_glyph}, 32'd0);
      check_count("reset_word_count", 0);

      // Glyph already on the pins at reset release: strobe after the 7th edge
      rst_n = 1'b1;
      bus.segments = SEG_H;
      bus.decimal  = 1'b1;
      clear_mon();
      first_edge = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (bus.glyph_strobe) begin
            strobes++;
            if (first_edge == 0) first_edge = i;
         end
      end
      check("latency_edges", 32'(first_edge), 32'd7);
      check("latency_one_strobe", 32'(strobes), 32'd1);
      check("latency_code_h", 32'(bus.glyph_code), 32'd0);
      clear_mon();
      hold(SEG_H, 1'b1, 10);
      check("held_no_restrobe", 32'(strobes), 32'd0);

      // Blank, then HELLO without gaps
      clear_mon();
      hold(SEG_BLK, 1'b1, 10);
      hold(SEG_H, 1'b1, 10);
      hold(SEG_E, 1'b1, 10);
      hold(SEG_L, 1'b1, 10);
      hold(SEG_O, 1'b1, 10);
      check("hello_codes", codes, 32'h0007_0123);
      check("hello_count", 32'(hellos), 32'd1);
      check("hello_on_o", 32'(hello_on_strobe), 32'd1);
      check("hello_no_rpog", 32'(rpogs), 32'd0);
      check_count("hello_word_count", 1);

      // R P O G separated by blanks, from fresh reset
      pulse_reset();
      clear_mon();
      hold(SEG_R, 1'b1, 10);
      hold(SEG_BLK, 1'b1, 10);
      hold(SEG_P, 1'b1, 10);
      hold(SEG_BLK, 1'b1, 10);
      hold(SEG_O, 1'b1, 10);
      hold(SEG_BLK, 1'b1, 10);
      hold(SEG_G, 1'b1, 10);
      check("rpog_codes", codes, 32'h0475_7376);
      check("rpog_count", 32'(rpogs), 32'd1);
      check("rpog_on_g", 32'(rpog_on_strobe), 32'd1);
      check("rpog_no_hello", 32'(hellos), 32'd0);
      check_count("rpog_word_count", 1);

      // Short all-lit glitch between H and E is filtered out
      clear_mon();
      hold(SEG_BLK, 1'b1, 10);
      hold(SEG_H, 1'b1, 10);
      hold(SEG_ALL, 1'b1, 3);
      hold(SEG_E, 1'b1, 10);
      hold(SEG_L, 1'b1, 10);
      hold(SEG_O, 1'b1, 10);
      check("glitch_codes", codes, 32'h0007_0123);
      check("glitch_no_bad", 32'(bads), 32'd0);
      check("glitch_hello_kept", 32'(hellos), 32'd1);
      check_count("glitch_word_count", 2);

      // Held unknown pattern: bad glyph, matcher returns to idle
      clear_mon();
      hold(SEG_ALL, 1'b1, 10);
      check("bad_strobe", 32'(strobes), 32'd1);
      check("bad_pulse_with_strobe", 32'(bad_on_strobe), 32'd1);
      check("bad_code", 32'(bus.glyph_code), 32'd7);
      clear_mon();
      hold(SEG_E, 1'b1, 10);
      hold(SEG_L, 1'b1, 10);
      hold(SEG_O, 1'b1, 10);
      check("bad_elo_codes", codes, 32'h0000_0123);
      check("bad_elo_no_hello", 32'(hellos), 32'd0);

      // Decimal low forces blank even with lit segments
      clear_mon();
      hold(SEG_H, 1'b0, 10);
      check("dp_low_blank", codes, 32'h0000_0007);

      // Reset while in HEL, then O: no word detected
      clear_mon();
      hold(SEG_H, 1'b1, 10);
      hold(SEG_E, 1'b1, 10);
      hold(SEG_L, 1'b1, 10);
      check("pre_reset_codes", codes, 32'h0000_0012);
      pulse_reset();
      clear_mon();
      hold(SEG_O, 1'b1, 10);
      check("post_reset_o_code", codes, 32'h0000_0003);
      check("post_reset_no_hello", 32'(hellos), 32'd0);
      check_count("post_reset_word_count", 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
